// File: rtl/arb_mux_rr.sv
// arb_mux_rr: NCH-channel, WIDTH-bit registered mux with round-robin arbitration and valid/ready handshakes.
// Define ARB_MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins, no pointer).
module arb_mux_rr #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SEL_W = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH*WIDTH-1:0] IN_DATA,
    input  logic [NCH-1:0]       IN_VALID,
    output logic [NCH-1:0]       IN_READY,
    output logic [WIDTH-1:0]     OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [SEL_W-1:0]     OUT_SEL
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic             can_accept;
    logic             transfer;
    int               idx;

    // Walk from the lowest-priority offset down to ptr so the nearest valid channel wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (IN_VALID[idx]) begin
                grant_idx = SEL_W'(idx);
                grant_any = 1'b1;
            end
        end
    end

    assign can_accept = !OUT_VALID || OUT_READY;
    assign transfer   = grant_any && can_accept && !RST;

    always_comb begin
        IN_READY = '0;
        if (transfer) begin
            IN_READY[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SEL   <= '0;
        end else if (transfer) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= IN_DATA[int'(grant_idx)*WIDTH +: WIDTH];
            OUT_SEL   <= grant_idx;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (grant_idx == SEL_W'(NCH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_rr.sv
// Bench for arb_mux_rr (NCH=4, WIDTH=32, round-robin build): directed vectors, a per-cycle
// reference model of the arbitration rules, and literal expectations that pin the model.
module tb_arb_mux_rr;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    logic                 clk;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_W-1:0]     out_sel;

    logic [WIDTH-1:0]     ch_data [NCH];

    int checks   = 0;
    int failures = 0;

    arb_mux_rr #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_SEL   (out_sel)
    );

    always_comb begin
        for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = ch_data[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: priority search from ptr modulo NCH, one-entry output register.
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    bit          m_ok = 0;

    initial begin
        int          win;
        logic [3:0]  exp_ready;
        forever begin
            @(negedge clk);
            win = -1;
            for (int k = 0; k < NCH; k++) begin
                if (win < 0 && in_valid[(m_ptr + k) % NCH]) win = (m_ptr + k) % NCH;
            end
            exp_ready = 4'b0000;
            if (win >= 0 && (!m_valid || out_ready) && !rst) exp_ready = 4'(1 << win);
            if (m_ok) begin
                check("model_in_ready", 32'(in_ready), 32'(exp_ready));
                check("model_out_valid", 32'(out_valid), 32'(m_valid));
                check("model_out_sel", 32'(out_sel), 32'(m_sel));
                check("model_out_data", out_data, m_data);
            end
            if (rst) begin
                m_ok    = 1;
                m_valid = 0;
                m_data  = '0;
                m_sel   = 0;
                m_ptr   = 0;
            end else if (exp_ready != 4'b0000) begin
                m_valid = 1;
                m_data  = ch_data[win];
                m_sel   = win;
                m_ptr   = (win + 1) % NCH;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic apply(input logic r, input logic [3:0] v, input logic rdy);
        rst       = r;
        in_valid  = v;
        out_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] tail_v [14] = '{4'hF, 4'hF, 4'h5, 4'hA, 4'h0, 4'h3, 4'h3, 4'hC, 4'h8, 4'h8, 4'h1, 4'h0, 4'h6, 4'hF};
    logic       tail_r [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [31:0] pat;
        pat = 32'h11111111;
        for (int i = 0; i < NCH; i++) ch_data[i] = 32'(i) * pat;

        // Reset held two cycles with every channel requesting.
        apply(1'b1, 4'hF, 1'b1);
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_sel", 32'(out_sel), 32'h0);

        // Fairness: all valid, continuous drain.
        apply(1'b0, 4'hF, 1'b1);
        check("first_grant_ch0", 32'(in_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_sel", 32'(out_sel), 32'(i % NCH));
            check("rr_data", out_data, 32'(i % NCH) * pat);
            check("rr_valid", 32'(out_valid), 32'h1);
        end

        // Sparse requests and wrap: move ptr to 3, then ch1 alone, then ch0+ch3.
        apply(1'b0, 4'b0100, 1'b1);
        tick();
        apply(1'b0, 4'b0010, 1'b1);
        check("sparse_ready_ch1", 32'(in_ready), 32'h2);
        tick();
        check("sparse_sel_ch1", 32'(out_sel), 32'h1);
        apply(1'b0, 4'b1001, 1'b1);
        check("wrap_ready_ch3", 32'(in_ready), 32'h8);
        tick();
        check("wrap_sel_ch3", 32'(out_sel), 32'h3);
        check("wrap_ready_ch0", 32'(in_ready), 32'h1);
        tick();
        check("wrap_sel_ch0", 32'(out_sel), 32'h0);

        // Backpressure: DEADBEEF from ch2 held through a 5-cycle stall.
        ch_data[2] = 32'hDEADBEEF;
        apply(1'b0, 4'b0100, 1'b1);
        tick();
        apply(1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_data", out_data, 32'hDEADBEEF);
            check("stall_sel", 32'(out_sel), 32'h2);
            check("stall_valid", 32'(out_valid), 32'h1);
            tick();
        end
        apply(1'b0, 4'b0001, 1'b1);
        check("unstall_ready_ch0", 32'(in_ready), 32'h1);
        tick();
        check("unstall_sel", 32'(out_sel), 32'h0);
        check("unstall_data", out_data, 32'h0);
        apply(1'b0, 4'b0000, 1'b1);
        tick();
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_sel_hold", 32'(out_sel), 32'h0);

        // Reset in the middle of a stall discards the beat and returns ptr to 0.
        apply(1'b0, 4'b0100, 1'b1);
        tick();
        apply(1'b0, 4'b0000, 1'b0);
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        apply(1'b1, 4'hF, 1'b0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        apply(1'b0, 4'hF, 1'b1);
        check("post_rst_ready_ch0", 32'(in_ready), 32'h1);
        tick();
        check("post_rst_sel", 32'(out_sel), 32'h0);

        // Mixed traffic checked by the model only.
        for (int s = 0; s < 14; s++) begin
            for (int i = 0; i < NCH; i++) ch_data[i] = {8'(s), 8'hA5, 16'(i)};
            apply(1'b0, tail_v[s], tail_r[s]);
            tick();
        end
        apply(1'b0, 4'h0, 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
